// File: rtl/sprite_line_fetcher_pkg.sv
// Shared video definitions for the sprite line fetcher: sprite attributes,
// FSM encoding, list entry layout and pattern address field positions.
package sprite_line_fetcher_pkg;

  localparam int unsigned PAT_ADDR_W     = 14;
  localparam int unsigned ADDR_BASE_BIT  = 13;
  localparam int unsigned ADDR_PAT_LSB   = 5;
  localparam int unsigned ADDR_ROW_LSB   = 2;
  localparam int unsigned ADDR_PLANE_LSB = 0;

  localparam logic SPR_ATTR_IS_SPRITE = 1'b1;
  localparam logic SPR_ATTR_HFLIP     = 1'b0;
  localparam logic SPR_ATTR_PALETTE   = 1'b1;
  localparam logic SPR_ATTR_PRIORITY  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } fetch_state_e;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] pattern;
    logic [3:0] row;
  } sprite_entry_t;

  // Planar pattern byte address; in 8x16 mode row[3] selects the odd pattern.
  function automatic logic [PAT_ADDR_W-1:0] pattern_addr(
    input logic       base,
    input logic       tall,
    input logic [7:0] pattern,
    input logic [3:0] row,
    input logic [1:0] plane
  );
    logic [7:0]            pat;
    logic [PAT_ADDR_W-1:0] a;
    pat = tall ? {pattern[7:1], row[3]} : pattern;
    a = '0;
    a[ADDR_BASE_BIT]           = base;
    a[ADDR_PAT_LSB +: 8]       = pat;
    a[ADDR_ROW_LSB +: 3]       = row[2:0];
    a[ADDR_PLANE_LSB +: 2]     = plane;
    return a;
  endfunction

endpackage

// File: rtl/sprite_line_fetcher_if.sv
// VRAM read port and renderer job port of the sprite line fetcher.
interface sprite_line_fetcher_if #(
  parameter int unsigned VADDR_W = 14
);
  logic [VADDR_W-1:0] vram_addr;
  logic               vram_req;
  logic               vram_ack;
  logic [7:0]         vram_data;

  logic [7:0]         render_idx;
  logic [31:0]        render_data;
  logic               render_start;
  logic               is_sprite;
  logic               hflip;
  logic               palette;
  logic               render_priority;
  logic               render_busy;
  logic               render_last_pixel;

  modport master (
    output vram_addr, vram_req,
    input  vram_ack, vram_data,
    output render_idx, render_data, render_start,
    output is_sprite, hflip, palette, render_priority,
    input  render_busy, render_last_pixel
  );

  modport slave (
    input  vram_addr, vram_req,
    output vram_ack, vram_data,
    input  render_idx, render_data, render_start,
    input  is_sprite, hflip, palette, render_priority,
    output render_busy, render_last_pixel
  );
endinterface

// File: rtl/sprite_planar_to_packed.sv
// Converts four 8-bit bit-planes into eight 4bpp pixels, leftmost pixel in
// the top nibble and plane 3 as the nibble MSB.
module sprite_planar_to_packed (
  input  logic [3:0][7:0] planes,
  output logic [31:0]     packed_px
);

  always_comb begin
    packed_px = '0;
    for (int i = 0; i < 8; i++) begin
      packed_px[31-4*i -: 4] = {planes[3][7-i], planes[2][7-i],
                                planes[1][7-i], planes[0][7-i]};
    end
  end

endmodule

// File: rtl/sprite_line_fetcher.sv
// Per-line sprite list, planar pattern fetch from VRAM and render job issue;
// the next entry's fetch overlaps the current entry's render.
module sprite_line_fetcher
  import sprite_line_fetcher_pkg::*;
#(
  parameter int unsigned MAX_SPRITES = 8,
  parameter int unsigned VADDR_W     = 14
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       list_clear,
  input  logic       list_wr,
  input  logic [7:0] list_x,
  input  logic [7:0] list_pattern,
  input  logic [3:0] list_row,
  input  logic       tall_sprites,
  input  logic       pattern_base,
  input  logic       start,
  output logic       done,
  output logic       busy,
  sprite_line_fetcher_if.master bus
);

  localparam int unsigned IDX_W = (MAX_SPRITES > 1) ? $clog2(MAX_SPRITES) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_SPRITES + 1);

  fetch_state_e        state_q, state_n;
  logic [IDX_W-1:0]    entry_q, entry_n;
  logic [CNT_W-1:0]    count_q;
  sprite_entry_t       list_q [MAX_SPRITES];

  logic [1:0]          plane_q;
  logic [3:0][7:0]     planes_q;
  logic                data_valid_q;
  logic                start_prev_q;
  logic                vram_req_q;
  logic [VADDR_W-1:0]  vram_addr_q;
  logic [7:0]          render_idx_q;
  logic [31:0]         render_data_q;
  logic                done_q;
  logic                busy_q;

  logic                issue_c;
  logic                fetch_go_c;
  logic [1:0]          plane_sel_c;
  logic [VADDR_W-1:0]  next_addr_c;
  logic [31:0]         packed_c;
  sprite_entry_t       addr_entry_c;
  sprite_entry_t       cur_entry_c;

  sprite_planar_to_packed u_p2p (
    .planes   (planes_q),
    .packed_px(packed_c)
  );

  // Next-state and control strobes
  always_comb begin
    state_n    = state_q;
    entry_n    = entry_q;
    issue_c    = 1'b0;
    fetch_go_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (count_q == '0) begin
            state_n = ST_DONE;
          end else begin
            state_n    = ST_FETCH;
            entry_n    = '0;
            fetch_go_c = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        if (bus.vram_ack && plane_q == 2'd3) state_n = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (data_valid_q && (!bus.render_busy || bus.render_last_pixel) && !start_prev_q) begin
          issue_c = 1'b1;
          if (CNT_W'(entry_q) + CNT_W'(1) < count_q) begin
            state_n    = ST_FETCH;
            entry_n    = entry_q + IDX_W'(1);
            fetch_go_c = 1'b1;
          end else begin
            state_n = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!bus.render_busy && !start_prev_q) state_n = ST_DONE;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Address of the next read: plane 0 on entering FETCH, else the following plane
  always_comb begin
    addr_entry_c = list_q[entry_n];
    cur_entry_c  = list_q[entry_q];
    plane_sel_c  = fetch_go_c ? 2'd0 : plane_q + 2'd1;
    next_addr_c  = VADDR_W'(pattern_addr(pattern_base, tall_sprites, addr_entry_c.pattern,
                                         addr_entry_c.row, plane_sel_c));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      entry_q       <= '0;
      count_q       <= '0;
      plane_q       <= '0;
      planes_q      <= '0;
      data_valid_q  <= 1'b0;
      start_prev_q  <= 1'b0;
      vram_req_q    <= 1'b0;
      vram_addr_q   <= '0;
      render_idx_q  <= '0;
      render_data_q <= '0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      for (int i = 0; i < int'(MAX_SPRITES); i++) list_q[i] <= '0;
    end else begin
      state_q      <= state_n;
      entry_q      <= entry_n;
      start_prev_q <= issue_c;
      busy_q       <= (state_n != ST_IDLE);
      done_q       <= (state_q == ST_DONE);

      if (fetch_go_c) begin
        vram_req_q  <= 1'b1;
        vram_addr_q <= next_addr_c;
        plane_q     <= 2'd0;
      end else if (state_q == ST_FETCH && bus.vram_ack) begin
        planes_q[plane_q] <= bus.vram_data;
        if (plane_q == 2'd3) begin
          vram_req_q   <= 1'b0;
          data_valid_q <= 1'b1;
        end else begin
          plane_q     <= plane_q + 2'd1;
          vram_addr_q <= next_addr_c;
        end
      end

      if (issue_c) begin
        data_valid_q  <= 1'b0;
        render_idx_q  <= cur_entry_c.x;
        render_data_q <= packed_c;
      end

      // List is only writable while idle; clear wins over append
      if (state_q == ST_IDLE) begin
        if (list_clear) begin
          count_q <= '0;
        end else if (list_wr && count_q < CNT_W'(MAX_SPRITES)) begin
          list_q[count_q[IDX_W-1:0]] <= '{x: list_x, pattern: list_pattern, row: list_row};
          count_q <= count_q + CNT_W'(1);
        end
      end
    end
  end

  // The job strobe shares its cycle with the renderer's last-pixel strobe, so
  // the new job's data is presented on that cycle and held until the next one.
  assign bus.render_start    = issue_c;
  assign bus.render_idx      = issue_c ? cur_entry_c.x : render_idx_q;
  assign bus.render_data     = issue_c ? packed_c : render_data_q;
  assign bus.vram_req        = vram_req_q;
  assign bus.vram_addr       = vram_addr_q;
  assign bus.is_sprite       = SPR_ATTR_IS_SPRITE;
  assign bus.hflip           = SPR_ATTR_HFLIP;
  assign bus.palette         = SPR_ATTR_PALETTE;
  assign bus.render_priority = SPR_ATTR_PRIORITY;
  assign done                = done_q;
  assign busy                = busy_q;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Directed bench for sprite_line_fetcher with VRAM and renderer models.
module tb_sprite_line_fetcher;

  localparam int RENDER_CYCLES = 8;

  logic       clk;
  logic       reset_n;
  logic       list_clear, list_wr;
  logic [7:0] list_x, list_pattern;
  logic [3:0] list_row;
  logic       tall_sprites, pattern_base, start;
  logic       done, busy;

  sprite_line_fetcher_if #(.VADDR_W(14)) bus ();

  sprite_line_fetcher #(.MAX_SPRITES(8), .VADDR_W(14)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .list_clear  (list_clear),
    .list_wr     (list_wr),
    .list_x      (list_x),
    .list_pattern(list_pattern),
    .list_row    (list_row),
    .tall_sprites(tall_sprites),
    .pattern_base(pattern_base),
    .start       (start),
    .done        (done),
    .busy        (busy),
    .bus         (bus)
  );

  typedef struct {
    logic [7:0]  idx;
    logic [31:0] data;
    logic        last;
  } job_t;

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  pat;
    logic [3:0]  row;
    logic        tall;
    logic        base;
    logic [7:0]  b0, b1, b2, b3;
    logic [13:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          max_ack_delay = 0;
  bit          req_seen;
  logic [7:0]  mem [16384];
  logic [13:0] addr_log [$];
  job_t        jobs [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_pack(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3);
    logic [31:0] r;
    r = '0;
    for (int px = 0; px < 8; px++) begin
      r = r << 4;
      r = r | {28'd0, b3[7-px], b2[7-px], b1[7-px], b0[7-px]};
    end
    return r;
  endfunction

  function automatic logic [13:0] model_addr(input logic base, input logic tall, input logic [7:0] pat,
                                             input logic [3:0] row, input int plane);
    int p;
    int a;
    p = tall ? ((int'(pat) & 32'hFE) | int'(row[3])) : int'(pat);
    a = (base ? 8192 : 0) + p * 32 + (int'(row) & 7) * 4 + plane;
    return 14'(a);
  endfunction

  function automatic logic [7:0] fill_byte(input int i, input int plane);
    return 8'(i * 37 + plane * 11 + 1);
  endfunction

  // VRAM: acknowledges each request after 0..max_ack_delay cycles
  initial begin : vram_model
    bit pending;
    int dly;
    pending = 1'b0;
    dly = 0;
    bus.vram_ack = 1'b0;
    bus.vram_data = 8'h00;
    forever begin
      tick();
      bus.vram_ack = 1'b0;
      if (!reset_n || !bus.vram_req) begin
        pending = 1'b0;
      end else begin
        if (!pending) begin
          pending = 1'b1;
          dly = (max_ack_delay == 0) ? 0 : int'($urandom_range(max_ack_delay, 0));
        end
        if (dly == 0) begin
          bus.vram_ack  = 1'b1;
          bus.vram_data = mem[bus.vram_addr];
          addr_log.push_back(bus.vram_addr);
          pending = 1'b0;
        end else begin
          dly--;
        end
      end
    end
  end

  // Renderer: busy RENDER_CYCLES cycles per job, last_pixel on the final one
  initial begin : render_model
    int  cnt;
    bit  st;
    cnt = 0;
    bus.render_busy = 1'b0;
    bus.render_last_pixel = 1'b0;
    forever begin
      @(negedge clk);
      st = bus.render_start;
      tick();
      if (!reset_n) cnt = 0;
      else if (st) cnt = RENDER_CYCLES;
      else if (cnt > 0) cnt--;
      bus.render_busy = (cnt != 0);
      bus.render_last_pixel = (cnt == 1);
    end
  end

  // Job monitor: logs strobes, no back-to-back strobes, job payload held between strobes
  initial begin : job_monitor
    bit          prev_start;
    bit          have_job;
    logic [39:0] held;
    prev_start = 1'b0;
    have_job = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_start = 1'b0;
        have_job = 1'b0;
      end else begin
        if (bus.vram_req) req_seen = 1'b1;
        if (bus.render_start) begin
          checks++;
          if (prev_start) begin
            errors++;
            $display("FAIL back_to_back_start: got start in consecutive cycles, expected a gap");
          end
          jobs.push_back('{idx: bus.render_idx, data: bus.render_data, last: bus.render_last_pixel});
          held = {bus.render_idx, bus.render_data};
          have_job = 1'b1;
        end else if (have_job) begin
          checks++;
          if ({bus.render_idx, bus.render_data} !== held) begin
            errors++;
            $display("FAIL render_hold: got 0x%010h, expected 0x%010h", {bus.render_idx, bus.render_data}, held);
          end
        end
        prev_start = bus.render_start;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
  endtask

  task automatic clear_list();
    list_clear = 1'b1;
    tick();
    list_clear = 1'b0;
  endtask

  task automatic write_entry(input logic [7:0] x, input logic [7:0] pat, input logic [3:0] row);
    list_wr = 1'b1;
    list_x = x;
    list_pattern = pat;
    list_row = row;
    tick();
    list_wr = 1'b0;
  endtask

  task automatic run_list(input int max_cycles);
    bit seen;
    addr_log.delete();
    jobs.delete();
    req_seen = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check1("busy_after_start", busy, 1'b1);
    seen = 1'b0;
    for (int n = 0; n < max_cycles; n++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check1("done_seen", seen, 1'b1);
    if (seen) check1("drained_at_done", bus.render_busy, 1'b0);
  endtask

  vec_t vecs [5];

  initial begin : main
    vecs[0] = '{8'h40, 8'h12, 4'd3,  1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h00, 14'h224C, 32'h11111111};
    vecs[1] = '{8'h05, 8'h00, 4'd0,  1'b0, 1'b0, 8'h80, 8'h80, 8'h80, 8'h81, 14'h0000, 32'hF0000008};
    vecs[2] = '{8'hFF, 8'h13, 4'd9,  1'b1, 1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF, 14'h0264, 32'hAAAAAAAA};
    vecs[3] = '{8'h80, 8'hA5, 4'd11, 1'b0, 1'b1, 8'h0F, 8'hF0, 8'h3C, 8'h01, 14'h34AC, 32'h22665519};
    vecs[4] = '{8'h33, 8'h13, 4'd5,  1'b1, 1'b1, 8'hAA, 8'h55, 8'h00, 8'h00, 14'h2254, 32'h12121212};

    reset_n = 1'b0;
    list_clear = 1'b0;
    list_wr = 1'b0;
    list_x = '0;
    list_pattern = '0;
    list_row = '0;
    tall_sprites = 1'b0;
    pattern_base = 1'b0;
    start = 1'b0;
    req_seen = 1'b0;
    clear_mem();
    repeat (3) tick();

    check1("rst_done", done, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_vram_req", bus.vram_req, 1'b0);
    check32("rst_vram_addr", 32'(bus.vram_addr), 32'h0);
    check1("rst_render_start", bus.render_start, 1'b0);
    check32("rst_render_idx", 32'(bus.render_idx), 32'h0);
    check32("rst_render_data", bus.render_data, 32'h0);
    check1("rst_is_sprite", bus.is_sprite, 1'b1);
    check1("rst_hflip", bus.hflip, 1'b0);
    check1("rst_palette", bus.palette, 1'b1);
    check1("rst_priority", bus.render_priority, 1'b0);

    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Single-entry vectors
    for (int v = 0; v < 5; v++) begin
      clear_mem();
      mem[vecs[v].exp_addr + 14'd0] = vecs[v].b0;
      mem[vecs[v].exp_addr + 14'd1] = vecs[v].b1;
      mem[vecs[v].exp_addr + 14'd2] = vecs[v].b2;
      mem[vecs[v].exp_addr + 14'd3] = vecs[v].b3;
      tall_sprites = vecs[v].tall;
      pattern_base = vecs[v].base;
      clear_list();
      write_entry(vecs[v].x, vecs[v].pat, vecs[v].row);
      run_list(200);
      check32($sformatf("vec%0d_reads", v), 32'(addr_log.size()), 32'd4);
      for (int k = 0; k < 4 && k < addr_log.size(); k++)
        check32($sformatf("vec%0d_addr%0d", v, k), 32'(addr_log[k]), 32'(vecs[v].exp_addr + 14'(k)));
      check32($sformatf("vec%0d_jobs", v), 32'(jobs.size()), 32'd1);
      if (jobs.size() > 0) begin
        check32($sformatf("vec%0d_idx", v), 32'(jobs[0].idx), 32'(vecs[v].x));
        check32($sformatf("vec%0d_data", v), jobs[0].data, vecs[v].exp_data);
      end
      tick();
    end

    // Eight entries, renderer busy 8 cycles: strobes overlap last_pixel
    clear_mem();
    tall_sprites = 1'b0;
    pattern_base = 1'b1;
    clear_list();
    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < 4; p++) mem[model_addr(1'b1, 1'b0, 8'(8'h30 + i), 4'(i), p)] = fill_byte(i, p);
      write_entry(8'(i * 16 + 3), 8'(8'h30 + i), 4'(i));
    end
    run_list(400);
    check32("eight_reads", 32'(addr_log.size()), 32'd32);
    for (int r = 0; r < 32 && r < addr_log.size(); r++)
      check32($sformatf("eight_addr%0d", r), 32'(addr_log[r]),
              32'(model_addr(1'b1, 1'b0, 8'(8'h30 + r / 4), 4'(r / 4), r % 4)));
    check32("eight_jobs", 32'(jobs.size()), 32'd8);
    for (int j = 0; j < 8 && j < jobs.size(); j++) begin
      check32($sformatf("eight_idx%0d", j), 32'(jobs[j].idx), 32'(j * 16 + 3));
      check32($sformatf("eight_data%0d", j), jobs[j].data,
              model_pack(fill_byte(j, 0), fill_byte(j, 1), fill_byte(j, 2), fill_byte(j, 3)));
      if (j > 0) check1($sformatf("eight_on_last%0d", j), jobs[j].last, 1'b1);
    end
    tick();

    // Ten writes saturate at eight; jitter on VRAM acks
    max_ack_delay = 2;
    clear_list();
    for (int i = 0; i < 10; i++) write_entry(8'(8'h20 + i), 8'(i), 4'(i));
    run_list(800);
    check32("sat_jobs", 32'(jobs.size()), 32'd8);
    for (int j = 0; j < 8 && j < jobs.size(); j++)
      check32($sformatf("sat_idx%0d", j), 32'(jobs[j].idx), 32'(8'h20 + j));
    tick();

    // Empty list: done two cycles after start, no VRAM traffic
    clear_list();
    jobs.delete();
    req_seen = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check1("empty_done_c1", done, 1'b0);
    check1("empty_busy_c1", busy, 1'b1);
    tick();
    check1("empty_done_c2", done, 1'b1);
    tick();
    check1("empty_done_c3", done, 1'b0);
    check1("empty_no_req", req_seen, 1'b0);
    check32("empty_jobs", 32'(jobs.size()), 32'd0);

    // Reset in the middle of a fetch with random ack delays
    max_ack_delay = 5;
    clear_mem();
    pattern_base = 1'b0;
    clear_list();
    for (int i = 0; i < 3; i++) write_entry(8'(8'h50 + i), 8'(8'h40 + i), 4'(i));
    addr_log.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    begin
      bit got;
      got = 1'b0;
      for (int n = 0; n < 100; n++) begin
        if (addr_log.size() >= 2) begin
          got = 1'b1;
          break;
        end
        tick();
      end
      check1("midfetch_reached", got, 1'b1);
    end
    @(negedge clk);
    check1("midfetch_req_held", bus.vram_req, 1'b1);
    reset_n = 1'b0;
    #1;
    check1("mrst_vram_req", bus.vram_req, 1'b0);
    check1("mrst_busy", busy, 1'b0);
    check1("mrst_done", done, 1'b0);
    check1("mrst_render_start", bus.render_start, 1'b0);
    check32("mrst_render_idx", 32'(bus.render_idx), 32'h0);
    check32("mrst_render_data", bus.render_data, 32'h0);
    check32("mrst_vram_addr", 32'(bus.vram_addr), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 4; p++) mem[model_addr(1'b0, 1'b0, 8'(8'h50 + i), 4'(2 + 4 * i), p)] = fill_byte(i + 9, p);
      write_entry(8'(8'h61 + i), 8'(8'h50 + i), 4'(2 + 4 * i));
    end
    run_list(400);
    check32("post_reads", 32'(addr_log.size()), 32'd8);
    for (int r = 0; r < 8 && r < addr_log.size(); r++)
      check32($sformatf("post_addr%0d", r), 32'(addr_log[r]),
              32'(model_addr(1'b0, 1'b0, 8'(8'h50 + r / 4), 4'(2 + 4 * (r / 4)), r % 4)));
    check32("post_jobs", 32'(jobs.size()), 32'd2);
    for (int j = 0; j < 2 && j < jobs.size(); j++) begin
      check32($sformatf("post_idx%0d", j), 32'(jobs[j].idx), 32'(8'h61 + j));
      check32($sformatf("post_data%0d", j), jobs[j].data,
              model_pack(fill_byte(j + 9, 0), fill_byte(j + 9, 1), fill_byte(j + 9, 2), fill_byte(j + 9, 3)));
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_line_fetcher.md
Name: sprite_line_fetcher

Overview:
- Upstream neighbour of the line renderer in the aqms video path.
- Holds the per-line sprite list written by sprite evaluation (up to 8 entries).
- For each entry: fetches the 4 planar pattern bytes of the current row from VRAM and converts them to packed 4bpp (8 pixels, 32 bits).
- Issues one render job per entry to the renderer, overlapping the next fetch with the current render.

Parameters:
- MAX_SPRITES, 8, list depth; sets the width of the count and index ports.
- VADDR_W, 14, VRAM byte address width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- list_clear  in  1  pulse: empty the list
- list_wr  in  1  append entry; ignored when the list is full
- list_x  in  8  sprite X (left pixel)
- list_pattern  in  8  pattern index
- list_row  in  4  row within sprite (0..15)
- tall_sprites  in  1  8x16 mode
- pattern_base  in  1  VRAM address bit 13 of pattern fetch
- start  in  1  pulse: begin fetch/render of the list
- done  out  1  pulse: all entries rendered
- busy  out  1  high from start until done
- vram_addr  out  VADDR_W  read address
- vram_req  out  1  read request, held until ack
- vram_ack  in  1  one-cycle; vram_data valid the same cycle
- vram_data  in  8  read data
- render_idx  out  8  to renderer
- render_data  out  32  packed pixels; pixel 0 (leftmost) in [31:28]
- render_start  out  1  one-cycle job strobe
- is_sprite  out  1  constant 1
- hflip  out  1  constant 0
- palette  out  1  constant 1 (sprite palette)
- render_priority  out  1  constant 0
- render_busy  in  1  renderer busy
- render_last_pixel  in  1  renderer last-pixel strobe

Behaviour:
- Reset values: all outputs 0 except the constants; list count 0; FSM IDLE.
- List:
  - 8 entries of {x, pattern, row}.
  - list_wr appends at index count; count saturates at MAX_SPRITES and further writes are dropped.
  - list_clear sets count to 0 and takes priority over a simultaneous list_wr.
  - A list_wr or list_clear while busy is ignored.
- Fetch address: {pattern_base, pat, row[2:0], plane[1:0]}, plane 0..3 in that order.
  - Normal mode: pat = pattern, and row[3] is ignored.
  - tall_sprites: pat = {pattern[7:1], row[3]}.
- FSM states:
  - IDLE: on start, go to FETCH with entry 0. If count==0, go straight to DONE.
  - FETCH: assert vram_req with the plane address. On each ack, latch the byte and advance the plane. After the plane-3 ack, pack and go to ISSUE.
  - ISSUE: assert render_start for one cycle when all of the following hold:
    - (!render_busy || render_last_pixel), and
    - no render_start was issued in the previous cycle, and
    - the packed data is valid.
  - After the issue in ISSUE:
    - If entries remain, go to FETCH for the next entry (its fetch overlaps the render).
    - Otherwise go to DRAIN.
  - DRAIN: wait until render_busy is low for one cycle with no render_start issued in the previous cycle, then go to DONE.
  - DONE: pulse done for one cycle, then IDLE.
- Packing: nibble for pixel i (i=0..7) = {p3[7-i], p2[7-i], p1[7-i], p0[7-i]}, placed in render_data[31-4i -: 4].
- render_idx = x unmodified; wrap past 255 is the renderer/line buffer's concern.
- render_data and render_idx are held stable from render_start until the next render_start.
- Entries are rendered in list order (index 0 first); the renderer gives earlier sprites priority.
- A start pulse while busy is ignored.
- A reset mid-operation returns to IDLE immediately. A vram_req dropped by reset is legal; the VRAM arbiter discards the pending request.
- vram_addr and vram_req change only on the cycle after an ack, or on entering FETCH.

Decomposition:
- Shared video package holds:
  - SPR_ATTR constants: palette=1, priority=0;
  - the FSM state encoding;
  - the pattern-address field positions.
- One sub-module, sprite_planar_to_packed: combinational 4x8-bit planes to 32-bit packed conversion. It is reusable by a future tile fetcher.

Test Plan:
- One entry {x=0x40, pat=0x12, row=3}, pattern_base=1, bytes 0xFF, 0x00, 0x00, 0x00:
  - reads at 0x2000|0x12<<5|3<<2 + 0..3 = 0x224C..0x224F;
  - render_start with idx=0x40, data=0x11111111;
  - done follows after the renderer drains.
- Planes 0x80, 0x80, 0x80, 0x81 -> data=0xF0000008.
- tall_sprites=1, pat=0x13, row=9 -> reads start at 0x0000|0x13<<5|1<<2 = 0x0264 (pattern_base=0).
- 8 entries with a renderer model busy for 8 cycles:
  - exactly 8 render_starts in list order;
  - a start coincides with last_pixel wherever allowed;
  - never two starts in consecutive cycles.
- 10 list_wr then start -> count saturates at 8; 8 jobs issued. A second run with count=0 -> done 2 cycles after start, no vram_req.
- Random vram_ack delays (0..5 cycles) with reset_n asserted mid-FETCH:
  - outputs return to reset values immediately;
  - the next start runs cleanly.
